fifo_uart_tx: RTL

Downstream drain stage for the byte FIFO: pops one byte at a time whenever the FIFO is non-empty and serialises it onto a single UART 8N1 line, LSB first. It sits between the FIFO read port and a dedicated output pin. Back-to-back frames are sent while data remains, and an enable input gates the start of new frames.

---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/fifo_uart_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT period.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + CW'(1);
      if (clear || (count_q == LAST)) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = !clear && (count_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time onto a UART 8N1 line, LSB first.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t            state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_q, bit_d;
   logic                      baud_clear;
   logic                      baud_tick;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .tick (baud_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
      end
   end

   // The baud timer is held at zero outside START/DATA/STOP, so each frame
   // starts with a full-length start bit.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_d      = bit_q;
      fifo_rd_en = 1'b0;
      tx         = UART_IDLE_LEVEL;
      busy       = 1'b1;
      frame_done = 1'b0;
      baud_clear = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (ena && !fifo_empty) begin
               state_d = POP;
            end
         end
         POP: begin
            fifo_rd_en = 1'b1;
            state_d    = LOAD;
         end
         LOAD: begin
            shift_d = fifo_rd_data;
            bit_d   = '0;
            state_d = START;
         end
         START: begin
            tx         = ~UART_IDLE_LEVEL;
            baud_clear = 1'b0;
            if (baud_tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            tx         = shift_q[0];
            baud_clear = 1'b0;
            if (baud_tick) begin
               shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            baud_clear = 1'b0;
            if (baud_tick) begin
               frame_done = 1'b1;
               state_d    = (ena && !fifo_empty) ? POP : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
